uart_rx_cmd_ctrl: RTL and testbench

Command-frame controller downstream of the UART receiver. Consumes the receiver's byte/data-valid stream, hunts for a sync byte, assembles address and data fields, optionally verifies an XOR checksum, and presents a complete register-write command on a valid/ready handshake. Handles inter-byte timeout and overrun so a broken or stalled serial link cannot wedge the register bus.

---
 rtl/uart_rx_cmd_ctrl_if.sv | 27 ++
 rtl/uart_rx_cmd_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_rx_cmd_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Byte stream and register-write command bundle for uart_rx_cmd_ctrl.
// master: UART side + command consumer (bench); slave: the controller.
interface uart_rx_cmd_ctrl_if #(
    parameter int DATA_BYTES = 2
);
    logic                    i_Rx_DV;
    logic [7:0]              i_Rx_Byte;
    logic                    o_Wr_Valid;
    logic                    i_Wr_Ready;
    logic [7:0]              o_Wr_Addr;
    logic [8*DATA_BYTES-1:0] o_Wr_Data;
    logic                    o_Err_Csum;
    logic                    o_Err_Timeout;
    logic                    o_Overrun;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Wr_Ready,
        input  o_Wr_Valid, o_Wr_Addr, o_Wr_Data,
        input  o_Err_Csum, o_Err_Timeout, o_Overrun
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Wr_Ready,
        output o_Wr_Valid, o_Wr_Addr, o_Wr_Data,
        output o_Err_Csum, o_Err_Timeout, o_Overrun
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// Frame decoder: SYNC, ADDR, DATA x DATA_BYTES [, CSUM] -> write command.
// Ports: i_Clock, i_Rst_n (async, active-low), bus (slave modport).
// Optional checksum byte enabled by macro UART_CMD_CHECKSUM_EN.
module uart_rx_cmd_ctrl #(
    parameter int          DATA_BYTES   = 2,
    parameter int          TIMEOUT_CLKS = 1000,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input logic                i_Clock,
    input logic                i_Rst_n,
    uart_rx_cmd_ctrl_if.slave  bus
);
    localparam int W  = 8 * DATA_BYTES;
    localparam int CW = $clog2(TIMEOUT_CLKS);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CLKS - 1);
    localparam logic [2:0]    IDX_LAST = 3'(DATA_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
`ifdef UART_CMD_CHECKSUM_EN
        S_CSUM,
`endif
        S_PEND
    } state_t;

    state_t          state;
    logic [7:0]      addr;
    logic [W-1:0]    data;
    logic [7:0]      csum;
    logic [2:0]      idx;
    logic [CW-1:0]   tcnt;
    logic            wr_valid;
    logic            err_csum;
    logic            err_to;
    logic            overrun;

    logic       dv;
    logic [7:0] rx;
    assign dv = bus.i_Rx_DV;
    assign rx = bus.i_Rx_Byte;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state    <= S_IDLE;
            addr     <= '0;
            data     <= '0;
            csum     <= '0;
            idx      <= '0;
            tcnt     <= '0;
            wr_valid <= 1'b0;
            err_csum <= 1'b0;
            err_to   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            err_csum <= 1'b0;
            err_to   <= 1'b0;
            overrun  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    csum <= '0;
                    tcnt <= '0;
                    if (dv && rx == SYNC_BYTE)
                        state <= S_ADDR;
                end
                S_ADDR: begin
                    if (dv) begin
                        addr  <= rx;
                        csum  <= csum ^ rx;
                        idx   <= '0;
                        tcnt  <= '0;
                        state <= S_DATA;
                    end else if (tcnt == TO_LAST) begin
                        err_to <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (dv) begin
                        // Shift in at the LSB end so byte 0 lands in the MSBs.
                        data <= (data << 8) | W'(rx);
                        csum <= csum ^ rx;
                        idx  <= idx + 1'b1;
                        tcnt <= '0;
                        if (idx == IDX_LAST) begin
`ifdef UART_CMD_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state    <= S_PEND;
                            wr_valid <= 1'b1;
`endif
                        end
                    end else if (tcnt == TO_LAST) begin
                        err_to <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                S_CSUM: begin
                    if (dv) begin
                        tcnt <= '0;
                        if (rx == csum) begin
                            state    <= S_PEND;
                            wr_valid <= 1'b1;
                        end else begin
                            err_csum <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end else if (tcnt == TO_LAST) begin
                        err_to <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
`endif
                S_PEND: begin
                    // The command is held; any byte arriving now is lost.
                    if (dv)
                        overrun <= 1'b1;
                    if (bus.i_Wr_Ready) begin
                        wr_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    wr_valid <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_Wr_Valid    = wr_valid;
    assign bus.o_Wr_Addr     = addr;
    assign bus.o_Wr_Data     = data;
    assign bus.o_Err_Timeout = err_to;
    assign bus.o_Overrun     = overrun;
`ifdef UART_CMD_CHECKSUM_EN
    assign bus.o_Err_Csum    = err_csum;
`else
    assign bus.o_Err_Csum    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Scoreboard bench for uart_rx_cmd_ctrl (DATA_BYTES=2, TIMEOUT_CLKS=1000).
// Stimulus queues expected commands/pulses; a negedge monitor checks them.
module tb_uart_rx_cmd_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_rx_cmd_ctrl_if #(.DATA_BYTES(2)) bus();

    uart_rx_cmd_ctrl #(
        .DATA_BYTES(2),
        .TIMEOUT_CLKS(1000),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .i_Clock(clk),
        .i_Rst_n(rst_n),
        .bus(bus.slave)
    );

    typedef enum int {K_CSUM, K_TMO, K_OVR} kind_e;
    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } cmd_t;

    kind_e pulse_q[$];
    cmd_t  cmd_q[$];
    int    checks = 0;
    int    errors = 0;

`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [7:0] OVR_BYTE = 8'h55;
`else
    localparam logic [7:0] OVR_BYTE = 8'h36;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic pulse(input kind_e k, input string nm);
        checks++;
        if (pulse_q.size() == 0 || pulse_q[0] != k) begin
            errors++;
            $display("FAIL %s: got unexpected pulse, expected none (%0d queued)",
                     nm, pulse_q.size());
        end else begin
            void'(pulse_q.pop_front());
        end
    endtask

    // Monitor: compare every accepted command and every pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_Wr_Valid && bus.i_Wr_Ready) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd: got addr %0h data %0h expected none",
                             bus.o_Wr_Addr, bus.o_Wr_Data);
                end else begin
                    cmd_t e;
                    e = cmd_q.pop_front();
                    chk("cmd_addr", 32'(bus.o_Wr_Addr), 32'(e.a));
                    chk("cmd_data", 32'(bus.o_Wr_Data), 32'(e.d));
                end
            end
            if (bus.o_Err_Csum)    pulse(K_CSUM, "err_csum");
            if (bus.o_Err_Timeout) pulse(K_TMO, "err_timeout");
            if (bus.o_Overrun)     pulse(K_OVR, "overrun");
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_Rx_Byte = b;
        bus.i_Rx_DV   = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Rx_DV   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [15:0] d);
        cmd_t c;
        c.a = a;
        c.d = d;
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d[15:8]);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(d[7:0]);
        chk("valid_before_last", 32'(bus.o_Wr_Valid), 0);
        cmd_q.push_back(c);
        send_byte(a ^ d[15:8] ^ d[7:0]);
`else
        chk("valid_before_last", 32'(bus.o_Wr_Valid), 0);
        cmd_q.push_back(c);
        send_byte(d[7:0]);
`endif
        chk("valid_rise", 32'(bus.o_Wr_Valid), 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, 32'(bus.o_Wr_Valid), 0);
        chk({nm, "_addr"}, 32'(bus.o_Wr_Addr), 0);
        chk({nm, "_data"}, 32'(bus.o_Wr_Data), 0);
        chk({nm, "_pulses"}, 32'({bus.o_Err_Csum, bus.o_Err_Timeout,
                                  bus.o_Overrun}), 0);
    endtask

    initial begin
        bus.i_Rx_DV    = 1'b0;
        bus.i_Rx_Byte  = 8'h00;
        bus.i_Wr_Ready = 1'b0;
        #12;
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Held command: 5 cycles ready low, then handshake.
        send_frame(8'h10, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(bus.o_Wr_Valid), 1);
            chk("hold_addr", 32'(bus.o_Wr_Addr), 32'h10);
            chk("hold_data", 32'(bus.o_Wr_Data), 32'h1234);
            if (i < 4) idle(1);
        end
        idle(1);
        bus.i_Wr_Ready = 1'b1;
        chk("hs_valid", 32'(bus.o_Wr_Valid), 1);
        idle(1);
        chk("valid_fall", 32'(bus.o_Wr_Valid), 0);
        bus.i_Wr_Ready = 1'b0;
        idle(2);

`ifdef UART_CMD_CHECKSUM_EN
        // Bad checksum, then a good frame.
        pulse_q.push_back(K_CSUM);
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h37);
        chk("valid_bad_csum", 32'(bus.o_Wr_Valid), 0);
        idle(3);
        chk("valid_bad_csum2", 32'(bus.o_Wr_Valid), 0);
        bus.i_Wr_Ready = 1'b1;
        send_frame(8'h10, 16'h1234);
        idle(1);
        bus.i_Wr_Ready = 1'b0;
        idle(2);
`endif

        // Overrun while pending; fields must not move.
        send_frame(8'h10, 16'h1234);
        idle(1);
        pulse_q.push_back(K_OVR);
        send_byte(OVR_BYTE);
        chk("ovr_valid", 32'(bus.o_Wr_Valid), 1);
        chk("ovr_addr", 32'(bus.o_Wr_Addr), 32'h10);
        chk("ovr_data", 32'(bus.o_Wr_Data), 32'h1234);
        idle(2);
        // Byte in the handshake cycle also overruns.
        pulse_q.push_back(K_OVR);
        bus.i_Wr_Ready = 1'b1;
        send_byte(8'h77);
        chk("hs_ovr_valid", 32'(bus.o_Wr_Valid), 0);
        idle(2);

        // Ready high before valid: one-cycle valid.
        send_frame(8'h3C, 16'hBEEF);
        idle(1);
        chk("short_valid", 32'(bus.o_Wr_Valid), 0);
        bus.i_Wr_Ready = 1'b0;

        // Noise in idle is ignored.
        send_byte(8'h00);
        send_byte(8'h10);
        chk("noise_valid", 32'(bus.o_Wr_Valid), 0);

        // Timeout after A5 10.
        pulse_q.push_back(K_TMO);
        send_byte(8'hA5);
        send_byte(8'h10);
        idle(1005);
        chk("tmo_valid", 32'(bus.o_Wr_Valid), 0);
        bus.i_Wr_Ready = 1'b1;
        send_frame(8'h44, 16'h5566);
        idle(2);

        // Long gap just inside the window: no timeout.
        send_byte(8'hA5);
        idle(998);
        send_byte(8'h21);
        send_byte(8'h0F);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'hF0);
        cmd_q.push_back('{8'h21, 16'h0FF0});
        send_byte(8'h21 ^ 8'h0F ^ 8'hF0);
`else
        cmd_q.push_back('{8'h21, 16'h0FF0});
        send_byte(8'hF0);
`endif
        chk("gap_valid", 32'(bus.o_Wr_Valid), 1);
        idle(2);
        bus.i_Wr_Ready = 1'b0;

        // Reset mid-frame.
        send_byte(8'hA5);
        send_byte(8'h10);
        send_byte(8'h12);
        chk("pre_rst_addr", 32'(bus.o_Wr_Addr), 32'h10);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        idle(2);
        rst_n = 1'b1;
        idle(1);
        bus.i_Wr_Ready = 1'b1;
        send_frame(8'h20, 16'hABCD);
        idle(3);

        chk("cmd_q_empty", 32'(cmd_q.size()), 0);
        chk("pulse_q_empty", 32'(pulse_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
